// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// div_pkg : shared types and constants for the sequential restoring divider
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned c_N_DEFAULT = 16;
    localparam int unsigned c_CNT_W     = $clog2(2 * c_N_DEFAULT);

    // Divide-by-zero quotient is all ones; this is the bit replicated across it.
    localparam logic c_DZ_QUOT_BIT = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//------------------------------------------------------------------------------
// div_step : one combinational restoring-division iteration (shift, trial sub)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int N = c_N_DEFAULT
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0]   w_shift;
    logic [N+1:0] w_sub;

    // rem_in is always below the divisor, so its top bit is zero and may be dropped.
    assign w_shift = {rem_in[N-1:0], bit_in};
    assign w_sub   = {1'b0, w_shift} - {2'b00, divisor};
    assign q_bit   = ~w_sub[N+1];
    assign rem_out = q_bit ? w_sub[N:0] : w_shift;

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
//------------------------------------------------------------------------------
// div_seq : sequential radix-2 restoring divider, 2N-bit / N-bit, 2N+1 latency
// Optional macro DIV_ZERO_FLAG_EN adds the dz port and divide-by-zero shortcut.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_seq
    import div_pkg::*;
#(
    parameter int N = c_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic           dz
`endif
);

    localparam int c_CNTW = cnt_width(N);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_finish;

    logic [c_CNTW-1:0]   r_cnt;
    logic [N:0]          r_rem;
    logic [2*N-1:0]      r_shift;
    logic [N-1:0]        r_div;
    logic [2*N-1:0]      r_quotient;
    logic [N-1:0]        r_remainder;
    logic                r_done;

    logic [N:0]          w_rem_next;
    logic                w_qbit;
    logic [2*N-1:0]      w_shift_next;

    div_step #(.N(N)) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_shift[2*N-1]),
        .divisor (r_div),
        .rem_out (w_rem_next),
        .q_bit   (w_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_shift_next = {r_shift[2*N-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef DIV_ZERO_FLAG_EN
    logic r_dz;
    logic r_dz_pend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_shift     <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            r_dz        <= 1'b0;
            r_dz_pend   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift <= dividend;
                r_div   <= divisor;
                r_rem   <= '0;
                r_cnt   <= c_CNTW'(2*N-1);
`ifdef DIV_ZERO_FLAG_EN
                r_dz      <= 1'b0;
                r_dz_pend <= (divisor == '0);
                // A zero divisor completes on the very next edge.
                if (divisor == '0) begin
                    r_cnt <= '0;
                end
`endif
            end else if (r_state == RUN) begin
                r_shift <= w_shift_next;
                r_rem   <= w_rem_next;
                r_cnt   <= r_cnt - c_CNTW'(1);
                if (w_finish) begin
                    r_done      <= 1'b1;
                    r_quotient  <= w_shift_next;
                    r_remainder <= w_rem_next[N-1:0];
`ifdef DIV_ZERO_FLAG_EN
                    if (r_dz_pend) begin
                        r_quotient  <= {(2*N){c_DZ_QUOT_BIT}};
                        r_remainder <= r_shift[N-1:0];
                        r_dz        <= 1'b1;
                        r_dz_pend   <= 1'b0;
                    end
`endif
                end
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
`ifdef DIV_ZERO_FLAG_EN
    assign dz        = r_dz;
`endif

endmodule

`default_nettype wire
